// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, imem addressing, IF/ID register, fetch counter
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  // PC is kept word aligned, so only bits [31:2] are stored.
  logic [29:0] pc_q,            pc_d;
  logic [31:0] ifid_instr_q,    ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q,    ifid_valid_d;
  logic [31:0] fetch_count_q,   fetch_count_d;

  logic [31:0] pc_full;
  logic [31:0] pc_plus4;

  // The low two bits of a redirect target carry no information for word fetches.
  logic unused_target_bits;
  assign unused_target_bits = ^redirect_target[1:0];

  assign pc_full   = {pc_q, 2'b00};
  assign pc_plus4  = pc_full + 32'd4;
  assign imem_addr = pc_full;

  // Next-state: stall holds everything, redirect squashes the wrong-path word, else advance.
  always_comb begin
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_count_d   = fetch_count_q;
    if (stall) begin
      // hold; a concurrent redirect is retaken once the stall drops
    end else if (redirect) begin
      pc_d            = redirect_target[31:2];
      ifid_instr_d    = NOP;
      ifid_pc_plus4_d = 32'd0;
      ifid_valid_d    = 1'b0;
    end else begin
      pc_d            = pc_plus4[31:2];
      ifid_instr_d    = imem_instr;
      ifid_pc_plus4_d = pc_plus4;
      ifid_valid_d    = 1'b1;
      fetch_count_d   = fetch_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset taking priority over any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= RESET_PC[31:2];
      ifid_instr_q    <= NOP;
      ifid_pc_plus4_q <= 32'd0;
      ifid_valid_q    <= 1'b0;
      fetch_count_q   <= 32'd0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .NOP(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .ifid_instr(ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid),
    .fetch_count(fetch_count)
  );

  // Asynchronous instruction memory, 64 words, address aliasing on bits [7:2].
  assign imem_instr = mem[imem_addr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc_plus4 = pc4;
    exp_q.push_back(e);
  endtask

  // Monitor: every new valid capture (fetch_count advancing by one) pops and compares.
  logic [31:0] prev_count = 32'hx;
  always @(negedge clk) begin
    if (fetch_count === prev_count + 32'd1) begin
      chk("capture_valid", {31'd0, ifid_valid}, 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_capture: got instr %h with empty scoreboard expected none", ifid_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", ifid_instr, e.instr);
        chk("sb_pc_plus4", ifid_pc_plus4, e.pc_plus4);
      end
    end
    prev_count = fetch_count;
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {16'hC0DE, 8'h00, i[7:0]};
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;

    // reset held two clocks
    step(); step();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    // sequential fetch of A, B
    reset = 1'b0;
    push(32'hC0DE_0000, 32'd4);
    push(32'hC0DE_0001, 32'd8);
    step();
    chk("seq1_addr", imem_addr, 32'd4);
    chk("seq1_count", fetch_count, 32'd1);
    step();
    chk("seq2_addr", imem_addr, 32'd8);
    chk("seq2_count", fetch_count, 32'd2);

    // stall two clocks after B
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_instr", ifid_instr, 32'hC0DE_0001);
      chk("stall_addr", imem_addr, 32'd8);
      chk("stall_count", fetch_count, 32'd2);
    end
    stall = 1'b0;
    push(32'hC0DE_0002, 32'd12);
    step();
    chk("seq3_addr", imem_addr, 32'd12);
    chk("seq3_count", fetch_count, 32'd3);

    // redirect to 0x43 (aligned to 0x40)
    redirect = 1'b1; redirect_target = 32'h43;
    step();
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
    chk("redir_instr", ifid_instr, 32'h0);
    chk("redir_pc4", ifid_pc_plus4, 32'h0);
    chk("redir_count", fetch_count, 32'd3);
    redirect = 1'b0;
    push(32'hC0DE_0010, 32'h44);
    step();
    chk("tgt_addr", imem_addr, 32'h44);
    chk("tgt_count", fetch_count, 32'd4);

    // stall and redirect together, then redirect alone
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h80;
    step();
    chk("sr_addr", imem_addr, 32'h44);
    chk("sr_instr", ifid_instr, 32'hC0DE_0010);
    chk("sr_valid", {31'd0, ifid_valid}, 32'd1);
    chk("sr_count", fetch_count, 32'd4);
    stall = 1'b0;
    step();
    chk("sr_redir_addr", imem_addr, 32'h80);
    chk("sr_redir_valid", {31'd0, ifid_valid}, 32'd0);
    redirect = 1'b0;
    push(32'hC0DE_0020, 32'h84);
    step();
    chk("sr_tgt_addr", imem_addr, 32'h84);
    chk("sr_tgt_count", fetch_count, 32'd5);

    // PC wrap at top of address space
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
    step();
    chk("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    push(32'hC0DE_003F, 32'h0);
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", ifid_pc_plus4, 32'h0);
    chk("wrap_count", fetch_count, 32'd6);

    // reset during a redirect discards it
    redirect = 1'b1; redirect_target = 32'h100; reset = 1'b1;
    step();
    chk("rr_addr", imem_addr, 32'h0);
    chk("rr_count", fetch_count, 32'd0);
    chk("rr_valid", {31'd0, ifid_valid}, 32'd0);
    reset = 1'b0; redirect = 1'b0;
    push(32'hC0DE_0000, 32'd4);
    step();
    chk("rr_fetch_addr", imem_addr, 32'd4);
    chk("rr_fetch_count", fetch_count, 32'd1);

    // let the monitor drain, then confirm every expected capture was seen
    stall = 1'b1;
    step(); step();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
